// File: rtl/keyvalue_cam.sv
// keyvalue_cam: key/value CAM behind a pipelined-bus style request port.
// One request per IDLE -> SEARCH -> RESP pass; response pulses for one cycle.
// Optional macro: KEYVALUE_DUP_UPDATE_EN (write to an existing key updates it
// in place; otherwise every write allocates a new entry).
module keyvalue_cam #(
  parameter int KEY_W = 8,
  parameter int VAL_W = 8,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1,
  localparam int DAT_W = (VAL_W > IDX_W) ? VAL_W : IDX_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             CYC_i,
  input  logic             STB_i,
  input  logic             WE_i,
  input  logic             DEL_i,
  input  logic [KEY_W-1:0] ADR_i,
  input  logic [VAL_W-1:0] DAT_i,
  output logic             ACK_o,
  output logic             ERR_o,
  output logic             STALL_o,
  output logic [DAT_W-1:0] DAT_o,
  output logic             FULL_o,
  output logic [CNT_W-1:0] COUNT_o
);

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t state, state_nxt;

  logic             valid [DEPTH];
  logic [KEY_W-1:0] keys  [DEPTH];
  logic [VAL_W-1:0] vals  [DEPTH];

  logic [KEY_W-1:0] req_key;
  logic [VAL_W-1:0] req_val;
  logic             req_we;
  logic             req_del;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             wr_hit;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; a dropped CYC_i during SEARCH abandons the request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CYC_i && STB_i) state_nxt = SEARCH;
      SEARCH:  state_nxt = CYC_i ? RESP : IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign STALL_o = (state != IDLE);

  // Parallel key match and free-slot search, lowest index wins
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit && valid[i] && (keys[i] == req_key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!free_found && !valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Whether a write may update an existing entry instead of allocating
  always_comb begin
`ifdef KEYVALUE_DUP_UPDATE_EN
    wr_hit = hit;
`else
    wr_hit = 1'b0;
`endif
  end

  // Request capture, storage update and response registration
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid[i] <= 1'b0;
        keys[i]  <= '0;
        vals[i]  <= '0;
      end
      req_key <= '0;
      req_val <= '0;
      req_we  <= 1'b0;
      req_del <= 1'b0;
      ACK_o   <= 1'b0;
      ERR_o   <= 1'b0;
      DAT_o   <= '0;
      FULL_o  <= 1'b0;
      COUNT_o <= '0;
    end else begin
      ACK_o <= 1'b0;
      ERR_o <= 1'b0;
      case (state)
        IDLE: begin
          if (CYC_i && STB_i) begin
            req_key <= ADR_i;
            req_val <= DAT_i;
            req_we  <= WE_i;
            req_del <= DEL_i;
          end
        end
        SEARCH: begin
          if (CYC_i) begin
            if (req_we) begin
              if (wr_hit) begin
                vals[hit_idx] <= req_val;
                DAT_o         <= DAT_W'(hit_idx);
                ACK_o         <= 1'b1;
              end else if (free_found) begin
                valid[free_idx] <= 1'b1;
                keys[free_idx]  <= req_key;
                vals[free_idx]  <= req_val;
                DAT_o           <= DAT_W'(free_idx);
                ACK_o           <= 1'b1;
                COUNT_o         <= COUNT_o + CNT_W'(1);
                FULL_o          <= (COUNT_o == CNT_W'(DEPTH - 1));
              end else begin
                DAT_o <= '0;
                ERR_o <= 1'b1;
              end
            end else if (req_del) begin
              if (hit) begin
                valid[hit_idx] <= 1'b0;
                DAT_o          <= DAT_W'(hit_idx);
                ACK_o          <= 1'b1;
                COUNT_o        <= COUNT_o - CNT_W'(1);
                FULL_o         <= 1'b0;
              end else begin
                DAT_o <= '0;
                ERR_o <= 1'b1;
              end
            end else begin
              if (hit) begin
                DAT_o <= DAT_W'(vals[hit_idx]);
                ACK_o <= 1'b1;
              end else begin
                DAT_o <= '0;
                ERR_o <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keyvalue_cam.sv
// Directed self-checking bench for keyvalue_cam (default parameters).
module tb_keyvalue_cam;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       CYC_i, STB_i, WE_i, DEL_i;
  logic [7:0] ADR_i, DAT_i;
  logic       ACK_o, ERR_o, STALL_o, FULL_o;
  logic [7:0] DAT_o;
  logic [3:0] COUNT_o;

  int passed = 0;
  int total  = 0;

  keyvalue_cam #(.KEY_W(8), .VAL_W(8), .DEPTH(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .CYC_i     (CYC_i),
    .STB_i     (STB_i),
    .WE_i      (WE_i),
    .DEL_i     (DEL_i),
    .ADR_i     (ADR_i),
    .DAT_i     (DAT_i),
    .ACK_o     (ACK_o),
    .ERR_o     (ERR_o),
    .STALL_o   (STALL_o),
    .DAT_o     (DAT_o),
    .FULL_o    (FULL_o),
    .COUNT_o   (COUNT_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    CYC_i = 1'b0; STB_i = 1'b0; WE_i = 1'b0; DEL_i = 1'b0;
    ADR_i = '0; DAT_i = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Full request with fixed-latency response checks
  task automatic op(input string tag, input logic we, input logic del,
                    input logic [7:0] key, input logic [7:0] val,
                    input logic exp_ack, input logic chk_dat, input logic [7:0] exp_dat);
    @(negedge sys_clk);
    CYC_i = 1'b1; STB_i = 1'b1; WE_i = we; DEL_i = del; ADR_i = key; DAT_i = val;
    @(posedge sys_clk); #1;
    STB_i = 1'b0;
    check({tag, ".stall"}, STALL_o, 1'b1);
    check({tag, ".early"}, {ACK_o, ERR_o}, 2'b00);
    @(posedge sys_clk); #1;
    check({tag, ".ack"}, ACK_o, exp_ack);
    check({tag, ".err"}, ERR_o, !exp_ack);
    if (chk_dat) check({tag, ".dat"}, DAT_o, exp_dat);
    @(posedge sys_clk); #1;
    check({tag, ".pulse"}, {ACK_o, ERR_o}, 2'b00);
    check({tag, ".idle"}, STALL_o, 1'b0);
    CYC_i = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b1;
    do_reset();
    #1;
    check("rst.ack", ACK_o, 1'b0);
    check("rst.err", ERR_o, 1'b0);
    check("rst.stall", STALL_o, 1'b0);
    check("rst.dat", DAT_o, 8'h00);
    check("rst.full", FULL_o, 1'b0);
    check("rst.count", COUNT_o, 4'd0);

    // Basic write then read
    op("wr12", 1'b1, 1'b0, 8'h12, 8'hA5, 1'b1, 1'b1, 8'h00);
    check("wr12.count", COUNT_o, 4'd1);
    op("rd12", 1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 1'b1, 8'hA5);

    // Fill remaining seven entries
    for (int i = 1; i < 8; i++) begin
      op("fill", 1'b1, 1'b0, 8'(8'h1F + i), 8'(8'h30 + i), 1'b1, 1'b1, 8'(i));
    end
    check("fill.count", COUNT_o, 4'd8);
    check("fill.full", FULL_o, 1'b1);

    op("wrfull", 1'b1, 1'b0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00);
    check("wrfull.count", COUNT_o, 4'd8);
    check("wrfull.full", FULL_o, 1'b1);

    // Key 0x22 lives at index 3
    op("del22", 1'b0, 1'b1, 8'h22, 8'h00, 1'b1, 1'b1, 8'h03);
    check("del22.count", COUNT_o, 4'd7);
    check("del22.full", FULL_o, 1'b0);
    op("wr77", 1'b1, 1'b0, 8'h77, 8'h55, 1'b1, 1'b1, 8'h03);
    check("wr77.full", FULL_o, 1'b1);
    op("rd22", 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 1'b1, 8'h00);
    op("rd77", 1'b0, 1'b0, 8'h77, 8'h00, 1'b1, 1'b1, 8'h55);
    op("rd26", 1'b0, 1'b0, 8'h26, 8'h00, 1'b1, 1'b1, 8'h37);
    op("delmiss", 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0, 1'b0, 8'h00);
    check("delmiss.count", COUNT_o, 4'd8);

    // Duplicate key handling
    do_reset();
    op("dup1", 1'b1, 1'b0, 8'h12, 8'h11, 1'b1, 1'b1, 8'h00);
`ifdef KEYVALUE_DUP_UPDATE_EN
    op("dup2", 1'b1, 1'b0, 8'h12, 8'h22, 1'b1, 1'b1, 8'h00);
    check("dup.count", COUNT_o, 4'd1);
    op("duprd", 1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 1'b1, 8'h22);
`else
    op("dup2", 1'b1, 1'b0, 8'h12, 8'h22, 1'b1, 1'b1, 8'h01);
    check("dup.count", COUNT_o, 4'd2);
    op("duprd", 1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 1'b1, 8'h11);
`endif

    // Abort by dropping CYC_i during SEARCH
    @(negedge sys_clk);
    CYC_i = 1'b1; STB_i = 1'b1; WE_i = 1'b1; DEL_i = 1'b0; ADR_i = 8'h40; DAT_i = 8'h01;
    @(posedge sys_clk); #1;
    STB_i = 1'b0; CYC_i = 1'b0;
    check("abort.stall", STALL_o, 1'b1);
    @(posedge sys_clk); #1;
    check("abort.resp1", {ACK_o, ERR_o}, 2'b00);
    check("abort.idle", STALL_o, 1'b0);
    @(posedge sys_clk); #1;
    check("abort.resp2", {ACK_o, ERR_o}, 2'b00);
`ifdef KEYVALUE_DUP_UPDATE_EN
    check("abort.count", COUNT_o, 4'd1);
`else
    check("abort.count", COUNT_o, 4'd2);
`endif
    op("abortrd", 1'b0, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'h00);

    // Reset asserted during SEARCH
    op("prerst", 1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 1'b1, 8'h11 + 8'h11 * 8'(`ifdef KEYVALUE_DUP_UPDATE_EN 1 `else 0 `endif));
    @(negedge sys_clk);
    CYC_i = 1'b1; STB_i = 1'b1; WE_i = 1'b1; DEL_i = 1'b0; ADR_i = 8'h41; DAT_i = 8'h02;
    @(posedge sys_clk); #1;
    STB_i = 1'b0;
    check("rstmid.stall", STALL_o, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check("rstmid.outs", {ACK_o, ERR_o, STALL_o, FULL_o}, 4'b0000);
    check("rstmid.dat", DAT_o, 8'h00);
    check("rstmid.count", COUNT_o, 4'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    CYC_i = 1'b0;
    @(posedge sys_clk); #1;
    check("rstmid.resp", {ACK_o, ERR_o}, 2'b00);
    op("rstrd12", 1'b0, 1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'h00);
    op("rstrd41", 1'b0, 1'b0, 8'h41, 8'h00, 1'b0, 1'b1, 8'h00);
    check("rstmid.count2", COUNT_o, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
